// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_pkg
// Purpose  : Shared Q-format widths, saturation limits and rounding bias for
//            the FFT datapath (twiddle_multiplier, fixed_point_adder).
// Revision : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

   // Q10.5 data words: 1 sign, 10 integer, 5 fractional bits
   localparam int Q10_5_W    = 16;
   localparam int Q10_5_FRAC = 5;

   // Q0.15 twiddle words: range -1 .. 1-2^-15
   localparam int Q0_15_W    = 16;
   localparam int Q0_15_FRAC = 15;

   // Saturation limits for a 16-bit signed result
   localparam logic [Q10_5_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [Q10_5_W-1:0] SAT_MIN = 16'h8000;

   // Half an LSB of the result, added before the Q0.15 right shift
   localparam int ROUND_BIAS = 1 << 14;

   typedef logic signed [Q10_5_W-1:0] q10_5_t;
   typedef logic signed [Q0_15_W-1:0] q0_15_t;

endpackage : fixed_point_pkg
`default_nettype wire

// File: rtl/fixed_point_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_round_sat
// Purpose  : Combinational round-half-up, arithmetic right shift and
//            saturation of a wide signed sum down to a Q10.5 word.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_round_sat
   import fixed_point_pkg::*;
#(
   parameter int IN_W  = 34,
   parameter int SHIFT = Q0_15_FRAC
) (
   input  logic [IN_W-1:0]    sum_in,
   output logic [Q10_5_W-1:0] result,
   output logic               sat
);

   // Thresholds are the 16-bit limits sign-extended to the working width so
   // the comparison is a plain signed compare of the shifted value.
   localparam logic signed [IN_W-1:0] C_BIAS = IN_W'(ROUND_BIAS);
   localparam logic signed [IN_W-1:0] C_MAX  = {{(IN_W-Q10_5_W){1'b0}}, SAT_MAX};
   localparam logic signed [IN_W-1:0] C_MIN  = {{(IN_W-Q10_5_W){1'b1}}, SAT_MIN};

   logic signed [IN_W-1:0] w_biased;
   logic signed [IN_W-1:0] w_shifted;

   // Round, shift, then clamp to the 16-bit signed range
   always_comb begin
      w_biased  = $signed(sum_in) + C_BIAS;
      w_shifted = w_biased >>> SHIFT;
      result    = w_shifted[Q10_5_W-1:0];
      sat       = 1'b0;
      if (w_shifted > C_MAX) begin
         result = SAT_MAX;
         sat    = 1'b1;
      end else if (w_shifted < C_MIN) begin
         result = SAT_MIN;
         sat    = 1'b1;
      end
   end

endmodule : fixed_point_round_sat
`default_nettype wire

// File: rtl/twiddle_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_multiplier
// Purpose  : 3-stage pipelined complex multiply (Q10.5 data x Q0.15 twiddle)
//            with round-half-up, saturation and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_multiplier
   import fixed_point_pkg::*;
#(
   parameter int DATA_W  = Q10_5_W,
   parameter int TW_W    = Q0_15_W,
   parameter int TW_FRAC = Q0_15_FRAC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data_re,
   input  logic [DATA_W-1:0] data_im,
   input  logic [TW_W-1:0]   tw_re,
   input  logic [TW_W-1:0]   tw_im,
   input  logic              ovf_clear,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              ovf
);

   // Product, sum and rounding widths; the rounding width leaves headroom so
   // 2^31 + bias cannot wrap.
   localparam int P_W = DATA_W + TW_W;
   localparam int S_W = P_W + 1;
   localparam int R_W = P_W + 2;

   logic                     r1_valid;
   logic signed [DATA_W-1:0] r1_dr, r1_di;
   logic signed [TW_W-1:0]   r1_wr, r1_wi;

   logic                     r2_valid;
   logic signed [P_W-1:0]    r2_rr, r2_ii, r2_ri, r2_ir;

   logic signed [S_W-1:0]    w_sum_re, w_sum_im;
   logic [DATA_W-1:0]        w_res_re, w_res_im;
   logic                     w_sat_re, w_sat_im;

   // Stage 1: register inputs and valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_dr    <= '0;
         r1_di    <= '0;
         r1_wr    <= '0;
         r1_wi    <= '0;
      end else begin
         r1_valid <= in_valid;
         r1_dr    <= data_re;
         r1_di    <= data_im;
         r1_wr    <= tw_re;
         r1_wi    <= tw_im;
      end
   end

   // Stage 2: four full-width signed partial products
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
         r2_rr    <= '0;
         r2_ii    <= '0;
         r2_ri    <= '0;
         r2_ir    <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_rr    <= P_W'(r1_dr) * P_W'(r1_wr);
         r2_ii    <= P_W'(r1_di) * P_W'(r1_wi);
         r2_ri    <= P_W'(r1_dr) * P_W'(r1_wi);
         r2_ir    <= P_W'(r1_di) * P_W'(r1_wr);
      end
   end

   // Stage 3 combine: one extra bit keeps 2^30 + 2^30 exact
   always_comb begin
      w_sum_re = S_W'(r2_rr) - S_W'(r2_ii);
      w_sum_im = S_W'(r2_ri) + S_W'(r2_ir);
   end

   fixed_point_round_sat #(
      .IN_W  (R_W),
      .SHIFT (TW_FRAC)
   ) u_round_sat_re (
      .sum_in (R_W'(w_sum_re)),
      .result (w_res_re),
      .sat    (w_sat_re)
   );

   fixed_point_round_sat #(
      .IN_W  (R_W),
      .SHIFT (TW_FRAC)
   ) u_round_sat_im (
      .sum_in (R_W'(w_sum_im)),
      .result (w_res_im),
      .sat    (w_sat_im)
   );

   // Stage 3 register: results hold on invalid slots; sticky ovf, set beats clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= r2_valid;
         if (r2_valid) begin
            out_re <= w_res_re;
            out_im <= w_res_im;
         end
         if (r2_valid && (w_sat_re || w_sat_im)) begin
            ovf <= 1'b1;
         end else if (ovf_clear) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule : twiddle_multiplier
`default_nettype wire
